plb_master_arbiter: RTL

//  Shares the single PLB IPIF master port between two single-beat requesters:

---
 rtl/plb_master_arbiter.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/plb_master_arbiter.sv
// Round-robin arbiter sharing one PLB IPIF master port between two single-beat
// requesters; latches the winning command and routes ack/complete/error back to it.
module plb_master_arbiter #(
  parameter int C_MST_AWIDTH = 32,
  parameter int C_MST_DWIDTH = 32,
  parameter int TIMEOUT_CYC  = 255
) (
  input  logic                        PLB_clk,
  input  logic                        reset,
  input  logic                        Bus2IP_Reset,
  input  logic                        m0_rd_req,
  input  logic                        m0_wr_req,
  input  logic [0:C_MST_AWIDTH-1]     m0_addr,
  input  logic [C_MST_DWIDTH/8-1:0]   m0_be,
  input  logic [C_MST_DWIDTH-1:0]     m0_wr_d,
  output logic                        m0_cmdack,
  output logic                        m0_cmplt,
  output logic                        m0_error,
  output logic [C_MST_DWIDTH-1:0]     m0_rd_d,
  output logic                        m0_rd_vld,
  input  logic                        m1_rd_req,
  input  logic                        m1_wr_req,
  input  logic [0:C_MST_AWIDTH-1]     m1_addr,
  input  logic [C_MST_DWIDTH/8-1:0]   m1_be,
  input  logic [C_MST_DWIDTH-1:0]     m1_wr_d,
  output logic                        m1_cmdack,
  output logic                        m1_cmplt,
  output logic                        m1_error,
  output logic [C_MST_DWIDTH-1:0]     m1_rd_d,
  output logic                        m1_rd_vld,
  output logic                        IP2Bus_MstRd_Req,
  output logic                        IP2Bus_MstWr_Req,
  output logic [0:C_MST_AWIDTH-1]     IP2Bus_Mst_Addr,
  output logic [C_MST_DWIDTH/8-1:0]   IP2Bus_Mst_BE,
  output logic                        IP2Bus_Mst_Lock,
  output logic                        IP2Bus_Mst_Reset,
  output logic [C_MST_DWIDTH-1:0]     IP2Bus_MstWr_d,
  input  logic                        Bus2IP_Mst_CmdAck,
  input  logic                        Bus2IP_Mst_Cmplt,
  input  logic                        Bus2IP_Mst_Error,
  input  logic                        Bus2IP_Mst_Rearbitrate,
  input  logic                        Bus2IP_Mst_Cmd_Timeout,
  input  logic [C_MST_DWIDTH-1:0]     Bus2IP_MstRd_d,
  input  logic                        Bus2IP_MstRd_src_rdy_n,
  input  logic                        Bus2IP_MstWr_dst_rdy_n
);

  localparam int BW = C_MST_DWIDTH / 8;
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_BACKOFF, S_XFER} state_t;

  state_t                    state;
  logic                      gnt;
  logic                      last_gnt;
  logic                      cmd_rd;
  logic                      cmd_wr;
  logic [0:C_MST_AWIDTH-1]   cmd_addr;
  logic [BW-1:0]             cmd_be;
  logic [C_MST_DWIDTH-1:0]   cmd_wr_d;
  logic [7:0]                tmo_cnt;

  logic rst_any, req0, req1, win;
  logic in_req, in_xfer, ack_hit, early_done, req_tmo, xfer_done, xfer_tmo;
  logic done, err, rd_vld_any;
  logic unused_dst_rdy;

  assign rst_any = reset | Bus2IP_Reset;
  assign req0    = m0_rd_req | m0_wr_req;
  assign req1    = m1_rd_req | m1_wr_req;
  assign win     = (req0 && req1) ? ~last_gnt : req1;

  // Control decode from registered state; reset blanks every strobe immediately.
  assign in_req     = (state == S_REQ)  && !rst_any;
  assign in_xfer    = (state == S_XFER) && !rst_any;
  assign ack_hit    = in_req && Bus2IP_Mst_CmdAck;
  assign early_done = ack_hit && Bus2IP_Mst_Cmplt;
  assign req_tmo    = in_req && !Bus2IP_Mst_CmdAck && Bus2IP_Mst_Cmd_Timeout;
  assign xfer_done  = in_xfer && Bus2IP_Mst_Cmplt;
  assign xfer_tmo   = in_xfer && !Bus2IP_Mst_Cmplt && (tmo_cnt == TMO_LAST);
  assign done       = early_done || req_tmo || xfer_done || xfer_tmo;
  assign err        = req_tmo || xfer_tmo || ((early_done || xfer_done) && Bus2IP_Mst_Error);
  assign rd_vld_any = (in_req || in_xfer) && cmd_rd && !Bus2IP_MstRd_src_rdy_n;

  assign m0_cmdack = ack_hit && !gnt;
  assign m1_cmdack = ack_hit &&  gnt;
  assign m0_cmplt  = done && !gnt;
  assign m1_cmplt  = done &&  gnt;
  assign m0_error  = done && err && !gnt;
  assign m1_error  = done && err &&  gnt;
  assign m0_rd_vld = rd_vld_any && !gnt;
  assign m1_rd_vld = rd_vld_any &&  gnt;
  assign m0_rd_d   = m0_rd_vld ? Bus2IP_MstRd_d : '0;
  assign m1_rd_d   = m1_rd_vld ? Bus2IP_MstRd_d : '0;

  assign IP2Bus_MstRd_Req = in_req && cmd_rd;
  assign IP2Bus_MstWr_Req = in_req && cmd_wr;
  assign IP2Bus_Mst_Addr  = cmd_addr;
  assign IP2Bus_Mst_BE    = cmd_be;
  assign IP2Bus_MstWr_d   = cmd_wr_d;
  assign IP2Bus_Mst_Lock  = 1'b0;
  assign IP2Bus_Mst_Reset = xfer_tmo;

  // Write-side handshake is observed by the IPIF itself; nothing here depends on it.
  assign unused_dst_rdy = Bus2IP_MstWr_dst_rdy_n;

  always_ff @(posedge PLB_clk) begin
    if (rst_any) begin
      state    <= S_IDLE;
      gnt      <= 1'b0;
      last_gnt <= 1'b1;
      cmd_rd   <= 1'b0;
      cmd_wr   <= 1'b0;
      cmd_addr <= '0;
      cmd_be   <= '0;
      cmd_wr_d <= '0;
      tmo_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req0 || req1) begin
            gnt <= win;
            // A port raising both requests is treated as a write.
            if (win) begin
              cmd_rd   <= m1_rd_req & ~m1_wr_req;
              cmd_wr   <= m1_wr_req;
              cmd_addr <= m1_addr;
              cmd_be   <= m1_be;
              cmd_wr_d <= m1_wr_d;
            end else begin
              cmd_rd   <= m0_rd_req & ~m0_wr_req;
              cmd_wr   <= m0_wr_req;
              cmd_addr <= m0_addr;
              cmd_be   <= m0_be;
              cmd_wr_d <= m0_wr_d;
            end
            state <= S_REQ;
          end
        end
        S_REQ: begin
          if (Bus2IP_Mst_CmdAck) begin
            if (Bus2IP_Mst_Cmplt) begin
              last_gnt <= gnt;
              state    <= S_IDLE;
            end else begin
              tmo_cnt <= '0;
              state   <= S_XFER;
            end
          end else if (Bus2IP_Mst_Cmd_Timeout) begin
            last_gnt <= gnt;
            state    <= S_IDLE;
          end else if (Bus2IP_Mst_Rearbitrate) begin
            state <= S_BACKOFF;
          end
        end
        S_BACKOFF: state <= S_REQ;
        S_XFER: begin
          if (Bus2IP_Mst_Cmplt || (tmo_cnt == TMO_LAST)) begin
            last_gnt <= gnt;
            state    <= S_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
